// File: rtl/llr_frame_loader_if.sv
// LLR loader bus: sample stream in, packed frame out.
// master = producer/consumer side, slave = loader side.
interface llr_frame_loader_if #(
  parameter int data_w = 8,
  parameter int in_w   = 12,
  parameter int R      = 24,
  parameter int D      = 24
);
  logic [in_w-1:0]         in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [R*D*data_w-1:0]   sig;
  logic                    sig_valid;
  logic                    sig_ack;
  logic                    err;

  modport master (
    output in_data, in_valid, in_last, sig_ack,
    input  in_ready, sig, sig_valid, err
  );

  modport slave (
    input  in_data, in_valid, in_last, sig_ack,
    output in_ready, sig, sig_valid, err
  );
endinterface

// File: rtl/llr_frame_loader.sv
// Ping-pong LLR frame loader: saturates samples, packs N=R*D per frame.
// Ports: clk, rst (sync, active-high), bus (slave side of loader if).
module llr_frame_loader #(
  parameter int data_w = 8,
  parameter int in_w   = 12,
  parameter int R      = 24,
  parameter int D      = 24
) (
  input  logic               clk,
  input  logic               rst,
  llr_frame_loader_if.slave  bus
);

  localparam int N  = R * D;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Symmetric clamp limits: the most-negative code is never produced.
  localparam logic signed [in_w-1:0] LIM_P =
    in_w'((2 ** (data_w - 1)) - 1);
  localparam logic signed [in_w-1:0] LIM_N = -LIM_P;
  localparam logic [data_w-1:0] OUT_P =
    {1'b0, {(data_w-1){1'b1}}};
  localparam logic [data_w-1:0] OUT_N =
    {1'b1, {(data_w-2){1'b0}}, 1'b1};

  logic [data_w-1:0] bank_q [2][N];

  logic [1:0]    full_q, full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic signed [in_w-1:0] din;
  logic [data_w-1:0]      sat;
  logic                   accept;
  logic                   at_last;
  logic                   ack;

  assign din     = bus.in_data;
  assign accept  = bus.in_valid & ~full_q[wr_sel_q];
  assign at_last = (cnt_q == LAST);
  assign ack     = bus.sig_ack & full_q[rd_sel_q];

  always_comb begin
    if (din > LIM_P)
      sat = OUT_P;
    else if (din < LIM_N)
      sat = OUT_N;
    else
      sat = din[data_w-1:0];
  end

  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    if (accept) begin
      if (at_last) begin
        // Frame completes on count; a missing last only flags err.
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        cnt_d            = '0;
        err_d            = ~bus.in_last;
      end else if (bus.in_last) begin
        // Early last: drop the partial frame, refill from slot 0.
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A bank being freed can't be the write bank on the same edge:
    // a full write bank holds in_ready low.
    if (ack) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < N; k++)
          bank_q[b][k] <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (accept)
        bank_q[wr_sel_q][cnt_q] <= sat;
    end
  end

  logic [N*data_w-1:0] sig_w;

  always_comb begin
    sig_w = '0;
    for (int k = 0; k < N; k++)
      sig_w[k*data_w +: data_w] = bank_q[rd_sel_q][k];
  end

  assign bus.sig       = sig_w;
  assign bus.sig_valid = full_q[rd_sel_q];
  assign bus.in_ready  = ~full_q[wr_sel_q];
  assign bus.err       = err_q;

endmodule

// File: doc/llr_frame_loader.md
Name: llr_frame_loader

Overview:
Upstream input stage for the LDPC decoder core. Accepts a serial stream of wide signed channel LLRs over a valid/ready handshake and saturates each sample to data_w bits. It packs R*D samples into a frame and presents the frame as the flat `sig` bus the decoder loads on `rst` or `term`. Ping-pong buffering lets frame n+1 stream in while the decoder iterates on frame n.

Parameters:
data_w, 8, output LLR width (signed two's complement)
in_w, 12, input sample width (signed two's complement, in_w >= data_w)
R, 24, block rows of the base matrix
D, 24, circulant size; frame length N = R*D = 576 samples

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_data  in  in_w  signed channel LLR sample
in_valid  in  1  in_data is valid this cycle
in_last  in  1  marks the final sample of a frame; qualified by in_valid
in_ready  out  1  loader can accept a sample this cycle
sig  out  R*D*data_w  packed frame; sample k occupies bits [k*data_w +: data_w]
sig_valid  out  1  sig holds a complete, unconsumed frame
sig_ack  in  1  consumer has latched sig; releases the read bank
err  out  1  one-cycle pulse on a frame-length mismatch

Behaviour:
- Storage: two banks, bank0 and bank1, each N*data_w bits.
  - Per-bank flag full[b]; pointers wr_sel and rd_sel; sample counter cnt (0..N-1, width clog2(N)).
- Reset (synchronous, rst=1 at a clock edge):
  - cnt=0, full=00, wr_sel=0, rd_sel=0, err=0.
  - Both banks cleared to zero, so sig=0.
  - sig_valid=0; in_ready=1 in the first cycle after reset.
  - Reset mid-frame discards all partial and complete frames.
- Handshake:
  - in_ready = ~full[wr_sel] (combinational).
  - A beat is accepted when in_valid & in_ready. in_data is ignored otherwise.
  - No combinational path from in_valid to in_ready.
- Saturation, applied to each accepted beat:
  - Symmetric clamp to [-(2^(data_w-1)-1), +(2^(data_w-1)-1)], i.e. ±127 at defaults.
  - The most-negative code (-128) is never produced, so min-sum magnitude and negation cannot overflow.
  - In-range values pass through unchanged (sign-truncated to data_w).
- Write:
  - Each accepted beat writes sample slot cnt of bank[wr_sel], then cnt increments.
  - On the beat with cnt==N-1: full[wr_sel] is set, wr_sel toggles, and cnt wraps to 0.
- Length errors:
  - Early last: in_last on an accepted beat with cnt<N-1. The beat is written, err pulses next cycle, cnt returns to 0, and the bank is not marked full. The partial frame is discarded and refilled from slot 0.
  - Missing last: cnt==N-1 with in_last=0. The frame still completes on count, and err pulses next cycle.
  - A correctly terminated frame (in_last with cnt==N-1) produces no err.
- Read:
  - sig = bank[rd_sel] and sig_valid = full[rd_sel], both registered state.
  - sig is stable while sig_valid=1.
  - Latency: sig_valid rises in the cycle after the clock edge that accepted the final beat, provided rd_sel points to that bank.
- Ack:
  - sig_ack with sig_valid=1 clears full[rd_sel] and toggles rd_sel at that edge.
  - sig_ack with sig_valid=0 is ignored.
  - If the other bank is already full, sig_valid stays 1 and sig switches to the next frame in the following cycle.
- Simultaneous events:
  - Frame completion and sig_ack on the same edge are both honoured.
  - If wr_sel==rd_sel at that edge, a bank that is full and being freed can never also be the write bank, because in_ready=0 for it. The freed bank becomes writable in the next cycle.
- Throughput: one sample per cycle sustained while the consumer acks within N cycles of sig_valid.
- Back-pressure: with both banks full, in_ready=0 until sig_ack.

Test Plan:
1. Reset, then stream 576 beats with in_data = k (k = 0..127 then wrapping), in_last on beat 575 -> sig_valid=1 one cycle after beat 575; sig slot k = k mod 128 (values ≤127); err never pulses.
2. Saturation beats 2047, -2048, -128, 127, -127, 5 -> slots read 127, -127, -127, 127, -127, 5; no slot ever reads 8'h80.
3. Stream three frames back-to-back with no sig_ack -> in_ready drops after beat 1151; frame0 is held on sig. Pulse sig_ack -> next cycle sig shows frame1 with sig_valid=1; in_ready=1 the cycle after; frame2 then loads.
4. Early last: in_last on beat 99 -> err pulses once; no sig_valid. The next 576 beats with a correct last form a valid frame whose slot 0 is the first beat after the error.
5. Missing last on beat 575 -> frame completes, sig_valid=1, and err pulses one cycle after beat 575.
6. Assert rst at beat 300 of frame1 while frame0 is valid -> sig_valid=0, sig=0, in_ready=1 on the next cycle; a fresh frame then loads into bank0.
